// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N:1 registered round-robin multiplexer.
package mux_nx1_rr_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage : mux_nx1_rr_pkg

// File: rtl/mux_nx1_rr_arbiter.sv
// Rotating-priority scan: the first requester after `last`, wrapping, ending at `last`.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    input  logic            en,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    int   idx;
    logic found;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (en && !found && req[idx]) begin
                gnt_idx = SELW'(idx);
                found   = 1'b1;
            end
        end
        any = found;
    end

endmodule : rr_arbiter

// File: rtl/mux_nx1_rr.sv
// N-input registered multiplexer with valid/ready per channel and
// manual or round-robin channel selection; one cycle of latency.
module mux_nx1_rr
    import mux_nx1_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
);

    logic            rr_mode;
    logic            load;
    logic [SELW-1:0] last;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;
    logic [SELW-1:0] cand;
    logic            hit;

    assign rr_mode = (mode == MODE_RR);
    assign load    = !out_valid || out_ready;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .last    (last),
        .en      (rr_mode),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // An out-of-range manual select never grants.
    always_comb begin
        cand = '0;
        hit  = 1'b0;
        if (rr_mode) begin
            cand = rr_idx;
            hit  = rr_any;
        end else begin
            cand = sel;
            if (int'(sel) < N) begin
                hit = in_valid[sel];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && hit) begin
            in_ready[cand] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SELW'(N - 1);
        end else if (load) begin
            if (hit) begin
                out_data  <= in_data[int'(cand)*WIDTH +: WIDTH];
                out_chan  <= cand;
                out_valid <= 1'b1;
                if (rr_mode) begin
                    last <= cand;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : mux_nx1_rr
